// File: rtl/time_date_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : time_date_counter_pkg
// Description : Shared constants, types and helpers for the calendar
//               time/date register bank: field widths, field ranges, reset
//               defaults and the days-per-month table.
// Ports       : (package, none)
// Revision    : 1.0 - initial release
// ============================================================================
package time_date_counter_pkg;

  // Field widths
  localparam int SEC_W    = 6;
  localparam int MINUTE_W = 6;
  localparam int HOUR_W   = 5;
  localparam int DAY_W    = 5;
  localparam int MONTH_W  = 4;
  localparam int YEAR_W   = 7;

  // Field ranges
  localparam logic [SEC_W-1:0]    SEC_MIN    = 6'd0;
  localparam logic [SEC_W-1:0]    SEC_MAX    = 6'd59;
  localparam logic [MINUTE_W-1:0] MINUTE_MIN = 6'd0;
  localparam logic [MINUTE_W-1:0] MINUTE_MAX = 6'd59;
  localparam logic [HOUR_W-1:0]   HOUR_MIN   = 5'd0;
  localparam logic [HOUR_W-1:0]   HOUR_MAX   = 5'd23;
  localparam logic [DAY_W-1:0]    DAY_MIN    = 5'd1;
  localparam logic [MONTH_W-1:0]  MONTH_MIN  = 4'd1;
  localparam logic [MONTH_W-1:0]  MONTH_MAX  = 4'd12;
  localparam logic [YEAR_W-1:0]   YEAR_MIN   = 7'd0;
  localparam logic [YEAR_W-1:0]   YEAR_MAX   = 7'd99;

  // Reset defaults
  localparam int unsigned DEFAULT_INIT_YEAR = 0;

  // Days per month for a non-leap year, indexed by month number.
  // Index 0 and 13..15 are not months; they report 31.
  localparam logic [DAY_W-1:0] DIM_TABLE [16] = '{
    5'd31,                                    // 0  (invalid)
    5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30, // Jan..Jun
    5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31, // Jul..Dec
    5'd31, 5'd31, 5'd31                       // 13..15 (invalid)
  };

  // Complete calendar state
  typedef struct packed {
    logic [YEAR_W-1:0]   year;
    logic [MONTH_W-1:0]  month;
    logic [DAY_W-1:0]    day;
    logic [HOUR_W-1:0]   hour;
    logic [MINUTE_W-1:0] minute;
    logic [SEC_W-1:0]    sec;
  } calendar_t;

  // Single-step adjust of one field with wrap inside [lo, hi].
  // Conflicting up/down leaves the value alone; a strobed field that is
  // out of range is forced to its minimum.
  function automatic logic [6:0] step_field(input logic [6:0] val,
                                            input logic [6:0] lo,
                                            input logic [6:0] hi,
                                            input logic       up,
                                            input logic       dn);
    logic [6:0] res;
    res = val;
    if (up ^ dn) begin
      if ((val < lo) || (val > hi)) begin
        res = lo;
      end else if (up) begin
        res = (val == hi) ? lo : val + 7'd1;
      end else begin
        res = (val == lo) ? hi : val - 7'd1;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/time_date_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : time_date_counter_if
// Description : Control strobes from the setting-mode unit and the calendar
//               field outputs of the time/date register bank.
// Ports       : run, tick_1hz, up_*/down_* (s, m, h, d, mo, y), mo_set  -> bank
//               sec, min, hour, day, month, year, century_wrap        <- bank
//               modport master : controller / consumer side
//               modport slave  : register bank side
// Revision    : 1.0 - initial release
// ============================================================================
interface time_date_counter_if;
  import time_date_counter_pkg::*;

  logic                run;
  logic                tick_1hz;
  logic                up_s,  down_s;
  logic                up_m,  down_m;
  logic                up_h,  down_h;
  logic                up_d,  down_d;
  logic                up_mo, down_mo;
  logic                up_y,  down_y;
  logic                mo_set;

  logic [SEC_W-1:0]    sec;
  logic [MINUTE_W-1:0] min;
  logic [HOUR_W-1:0]   hour;
  logic [DAY_W-1:0]    day;
  logic [MONTH_W-1:0]  month;
  logic [YEAR_W-1:0]   year;
  logic                century_wrap;

  modport master (
    output run, tick_1hz,
    output up_s, down_s, up_m, down_m, up_h, down_h,
    output up_d, down_d, up_mo, down_mo, up_y, down_y,
    output mo_set,
    input  sec, min, hour, day, month, year, century_wrap
  );

  modport slave (
    input  run, tick_1hz,
    input  up_s, down_s, up_m, down_m, up_h, down_h,
    input  up_d, down_d, up_mo, down_mo, up_y, down_y,
    input  mo_set,
    output sec, min, hour, day, month, year, century_wrap
  );

endinterface
`default_nettype wire

// File: rtl/time_date_counter_month_days.sv
`default_nettype none
// ============================================================================
// Module      : month_days
// Description : Combinational days-in-month lookup. February has 29 days
//               when leap is set. Non-month codes return 31.
// Ports       : month [3:0] in  - month number 1..12
//               leap        in  - current year is a leap year
//               dim   [4:0] out - number of days in that month
// Revision    : 1.0 - initial release
// ============================================================================
module month_days
  import time_date_counter_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic               leap,
  output logic [DAY_W-1:0]   dim
);

  always_comb begin
    dim = DIM_TABLE[month];
    if ((month == 4'd2) && leap) begin
      dim = 5'd29;
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_date_counter.sv
`default_nettype none
// ============================================================================
// Module      : time_date_counter
// Description : Calendar register bank for years 2000..2099. Counts seconds
//               through years on a 1 Hz tick in run mode; applies single-step
//               field adjustments (no carries) in set mode, re-clamping the
//               day of month whenever month or year changes or on mo_set.
// Ports       : clk          in  - system clock
//               rst_n        in  - asynchronous active-low reset
//               bus          slave modport of time_date_counter_if
//                            (run, tick_1hz, adjust strobes, mo_set in;
//                             sec..year, century_wrap out)
// Parameters  : INIT_YEAR    year field loaded at reset (0..99)
// Revision    : 1.0 - initial release
// ============================================================================
module time_date_counter
  import time_date_counter_pkg::*;
#(
  parameter int unsigned INIT_YEAR = DEFAULT_INIT_YEAR
)(
  input  logic                 clk,
  input  logic                 rst_n,
  time_date_counter_if.slave   bus
);

  localparam logic [YEAR_W-1:0] INIT_YEAR_V = YEAR_W'(INIT_YEAR);

  calendar_t           cal_q, cal_d;
  logic                wrap_q, wrap_d;

  // Tick cascade uses the current month/year.
  logic                leap_cur;
  logic [DAY_W-1:0]    dim_cur;

  // Set path evaluates month/year first, then checks the day against them.
  logic [MONTH_W-1:0]  month_adj;
  logic [YEAR_W-1:0]   year_adj;
  logic                leap_new;
  logic [DAY_W-1:0]    dim_new;
  logic [DAY_W-1:0]    day_base;
  logic                reclamp;

  logic                carry_s, carry_m, carry_h, carry_d, carry_mo;

  assign leap_cur  = (cal_q.year[1:0] == 2'b00);
  assign month_adj = MONTH_W'(step_field(7'(cal_q.month), 7'(MONTH_MIN),
                                         7'(MONTH_MAX), bus.up_mo, bus.down_mo));
  assign year_adj  = step_field(cal_q.year, YEAR_MIN, YEAR_MAX,
                                bus.up_y, bus.down_y);
  assign leap_new  = (year_adj[1:0] == 2'b00);

  month_days u_dim_cur (
    .month (cal_q.month),
    .leap  (leap_cur),
    .dim   (dim_cur)
  );

  month_days u_dim_new (
    .month (month_adj),
    .leap  (leap_new),
    .dim   (dim_new)
  );

  assign reclamp = (month_adj != cal_q.month) || (year_adj != cal_q.year) ||
                   bus.mo_set;

  always_comb begin
    cal_d    = cal_q;
    wrap_d   = 1'b0;
    carry_s  = 1'b0;
    carry_m  = 1'b0;
    carry_h  = 1'b0;
    carry_d  = 1'b0;
    carry_mo = 1'b0;
    day_base = cal_q.day;

    if (bus.run) begin
      if (bus.tick_1hz) begin
        // ">= max" also sends any out-of-range value to the minimum; only an
        // exact max produces a carry.
        carry_s   = (cal_q.sec == SEC_MAX);
        cal_d.sec = (cal_q.sec >= SEC_MAX) ? SEC_MIN : cal_q.sec + 6'd1;
        if (carry_s) begin
          carry_m      = (cal_q.minute == MINUTE_MAX);
          cal_d.minute = (cal_q.minute >= MINUTE_MAX) ? MINUTE_MIN
                                                      : cal_q.minute + 6'd1;
        end
        if (carry_m) begin
          carry_h    = (cal_q.hour == HOUR_MAX);
          cal_d.hour = (cal_q.hour >= HOUR_MAX) ? HOUR_MIN : cal_q.hour + 5'd1;
        end
        if (carry_h) begin
          carry_d   = (cal_q.day == dim_cur);
          cal_d.day = (cal_q.day >= dim_cur) ? DAY_MIN : cal_q.day + 5'd1;
        end
        if (carry_d) begin
          carry_mo    = (cal_q.month == MONTH_MAX);
          cal_d.month = (cal_q.month >= MONTH_MAX) ? MONTH_MIN
                                                   : cal_q.month + 4'd1;
        end
        if (carry_mo) begin
          wrap_d     = (cal_q.year == YEAR_MAX);
          cal_d.year = (cal_q.year >= YEAR_MAX) ? YEAR_MIN
                                                : cal_q.year + 7'd1;
        end
      end
    end else begin
      cal_d.sec    = SEC_W'(step_field(7'(cal_q.sec), 7'(SEC_MIN), 7'(SEC_MAX),
                                       bus.up_s, bus.down_s));
      cal_d.minute = MINUTE_W'(step_field(7'(cal_q.minute), 7'(MINUTE_MIN),
                                          7'(MINUTE_MAX), bus.up_m, bus.down_m));
      cal_d.hour   = HOUR_W'(step_field(7'(cal_q.hour), 7'(HOUR_MIN),
                                        7'(HOUR_MAX), bus.up_h, bus.down_h));
      cal_d.month  = month_adj;
      cal_d.year   = year_adj;

      // Clamp first, so a day adjust in the same cycle steps from the
      // clamped value against the new month length.
      if (reclamp && (cal_q.day > dim_new)) begin
        day_base = dim_new;
      end
      cal_d.day = DAY_W'(step_field(7'(day_base), 7'(DAY_MIN), 7'(dim_new),
                                    bus.up_d, bus.down_d));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_q.sec    <= SEC_MIN;
      cal_q.minute <= MINUTE_MIN;
      cal_q.hour   <= HOUR_MIN;
      cal_q.day    <= DAY_MIN;
      cal_q.month  <= MONTH_MIN;
      cal_q.year   <= INIT_YEAR_V;
      wrap_q       <= 1'b0;
    end else begin
      cal_q        <= cal_d;
      wrap_q       <= wrap_d;
    end
  end

  assign bus.sec          = cal_q.sec;
  assign bus.min          = cal_q.minute;
  assign bus.hour         = cal_q.hour;
  assign bus.day          = cal_q.day;
  assign bus.month        = cal_q.month;
  assign bus.year         = cal_q.year;
  assign bus.century_wrap = wrap_q;

endmodule
`default_nettype wire
